// File: rtl/rvlab_mmcm_drp_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : rvlab_mmcm_drp_seq_if
//  Brief    : Request/response, MMCM DRP and MMCM reset/lock bundle used by
//             the CLKOUT0 divide sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface rvlab_mmcm_drp_seq_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [7:0]  req_div_i;
    logic        resp_valid_o;
    logic [1:0]  resp_status_o;
    logic        busy_o;
    logic        drp_en_o;
    logic        drp_we_o;
    logic [6:0]  drp_adr_o;
    logic [15:0] drp_di_o;
    logic        drp_rdy_i;
    logic [15:0] drp_do_i;
    logic        mmcm_rst_o;
    logic        mmcm_locked_i;

    // Sequencer side
    modport slave (
        input  req_valid_i, req_div_i, drp_rdy_i, drp_do_i, mmcm_locked_i,
        output req_ready_o, resp_valid_o, resp_status_o, busy_o,
               drp_en_o, drp_we_o, drp_adr_o, drp_di_o, mmcm_rst_o
    );

    // Register front end plus MMCM side
    modport master (
        output req_valid_i, req_div_i, drp_rdy_i, drp_do_i, mmcm_locked_i,
        input  req_ready_o, resp_valid_o, resp_status_o, busy_o,
               drp_en_o, drp_we_o, drp_adr_o, drp_di_o, mmcm_rst_o
    );
endinterface
`default_nettype wire

// File: rtl/rvlab_mmcm_drp_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rvlab_mmcm_drp_seq
//  Brief    : Runtime CLKOUT0 divide change for the system MMCM. Holds the
//             MMCM in reset, read-modify-writes ClkReg1/ClkReg2 over DRP,
//             releases reset, waits for lock and reports a status code.
//  Revision : 1.0 - initial release
// ============================================================================
module rvlab_mmcm_drp_seq #(
    parameter int DIV_MIN        = 6,
    parameter int DIV_MAX        = 128,
    parameter int DRDY_TIMEOUT   = 64,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int RST_MIN_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    rvlab_mmcm_drp_seq_if.slave     bus
);
    localparam int c_DCNT_W = $clog2(DRDY_TIMEOUT + 1) + 1;
    localparam int c_RCNT_W = $clog2(RST_MIN_CYCLES + 1) + 1;
    localparam int c_LCNT_W = $clog2(LOCK_TIMEOUT + 1) + 1;
    localparam logic [c_DCNT_W-1:0] c_DRDY_TO   = c_DCNT_W'(DRDY_TIMEOUT);
    localparam logic [c_RCNT_W-1:0] c_RST_MIN   = c_RCNT_W'(RST_MIN_CYCLES);
    localparam logic [c_LCNT_W-1:0] c_LOCK_TO   = c_LCNT_W'(LOCK_TIMEOUT);
    localparam logic [c_LCNT_W-1:0] c_LOCK_SKIP = c_LCNT_W'(4);
    localparam logic [1:0] c_ST_OK = 2'b00, c_ST_BAD = 2'b01,
                           c_ST_DRP = 2'b10, c_ST_LOCK = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_ASSERT_RST = 4'd1, S_RD1 = 4'd2, S_WT_RD1 = 4'd3,
        S_WR1 = 4'd4, S_WT_WR1 = 4'd5, S_RD2 = 4'd6, S_WT_RD2 = 4'd7,
        S_WR2 = 4'd8, S_WT_WR2 = 4'd9, S_HOLD = 4'd10, S_RELEASE = 4'd11,
        S_WAIT_LOCK = 4'd12, S_RESP = 4'd13
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [7:0]          r_div, w_div_nxt;
    logic [5:0]          r_rd_hi, w_rd_hi_nxt;   // preserved readback bits [15:10]
    logic [1:0]          r_code, w_code_nxt;
    logic [c_DCNT_W-1:0] r_drp_cnt;
    logic [c_RCNT_W-1:0] r_rst_cnt;
    logic [c_LCNT_W-1:0] r_lock_cnt;
    logic                r_lock_meta, r_lock_sync;
    logic                r_req_ready, r_busy, r_resp_valid, r_mmcm_rst;
    logic [1:0]          r_resp_status;
    logic                r_drp_en, r_drp_we;
    logic [6:0]          r_drp_adr;
    logic [15:0]         r_drp_di;
    logic                w_en_nxt, w_we_nxt, w_rst_nxt, w_idle_nxt;
    logic [6:0]          w_adr_nxt;
    logic [15:0]         w_di_nxt;
    logic [6:0]          w_high, w_low;

    // Divider fields; d=128 wraps to 0/0 in the 6-bit register fields
    assign w_high = r_div[7:1];
    assign w_low  = 7'(r_div - {1'b0, r_div[7:1]});

    // Next-state logic and next values of the registered outputs
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_rd_hi_nxt = r_rd_hi;
        w_code_nxt  = r_code;
        unique case (r_state)
            S_IDLE: if (bus.req_valid_i && r_req_ready) begin
                w_div_nxt = bus.req_div_i;
                if ((bus.req_div_i < 8'(DIV_MIN)) || (bus.req_div_i > 8'(DIV_MAX))) begin
                    w_code_nxt  = c_ST_BAD;
                    w_state_nxt = S_RESP;
                end else begin
                    w_code_nxt  = c_ST_OK;
                    w_state_nxt = S_ASSERT_RST;
                end
            end
            S_ASSERT_RST: w_state_nxt = S_RD1;
            S_RD1:        w_state_nxt = S_WT_RD1;
            S_WR1:        w_state_nxt = S_WT_WR1;
            S_RD2:        w_state_nxt = S_WT_RD2;
            S_WR2:        w_state_nxt = S_WT_WR2;
            S_WT_RD1, S_WT_WR1, S_WT_RD2, S_WT_WR2: begin
                if (bus.drp_rdy_i) begin
                    if (r_state == S_WT_RD1 || r_state == S_WT_RD2)
                        w_rd_hi_nxt = bus.drp_do_i[15:10];
                    unique case (r_state)
                        S_WT_RD1: w_state_nxt = S_WR1;
                        S_WT_WR1: w_state_nxt = S_RD2;
                        S_WT_RD2: w_state_nxt = S_WR2;
                        default:  w_state_nxt = S_HOLD;
                    endcase
                end else if (r_drp_cnt >= c_DRDY_TO) begin
                    w_code_nxt  = c_ST_DRP;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_HOLD:    if (r_rst_cnt >= c_RST_MIN) w_state_nxt = S_RELEASE;
            S_RELEASE: w_state_nxt = (r_code == c_ST_DRP) ? S_RESP : S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (r_lock_cnt >= c_LOCK_SKIP && r_lock_sync) begin
                    w_code_nxt  = c_ST_OK;
                    w_state_nxt = S_RESP;
                end else if (r_lock_cnt >= c_LOCK_TO) begin
                    w_code_nxt  = c_ST_LOCK;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        w_en_nxt  = w_state_nxt inside {S_RD1, S_WR1, S_RD2, S_WR2};
        w_we_nxt  = w_state_nxt inside {S_WR1, S_WR2};
        w_rst_nxt = w_state_nxt inside {S_ASSERT_RST, S_RD1, S_WT_RD1, S_WR1, S_WT_WR1,
                                        S_RD2, S_WT_RD2, S_WR2, S_WT_WR2, S_HOLD};
        w_adr_nxt = 7'h00;
        w_di_nxt  = 16'h0000;
        if (w_state_nxt inside {S_RD1, S_WR1}) w_adr_nxt = 7'h08;
        if (w_state_nxt inside {S_RD2, S_WR2}) w_adr_nxt = 7'h09;
        if (w_state_nxt == S_WR1) w_di_nxt = {w_rd_hi_nxt[5:2], w_high[5:0], w_low[5:0]};
        if (w_state_nxt == S_WR2) w_di_nxt = {w_rd_hi_nxt, 2'b00, r_div[0], 1'b0, 6'b000000};
        // The response cycle itself still counts as busy
        w_idle_nxt = (w_state_nxt == S_IDLE) && (r_state != S_RESP);
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Request latch, readback capture, status code and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_div <= '0; r_rd_hi <= '0; r_code <= '0;
            r_req_ready <= 1'b1; r_busy <= 1'b0;
            r_resp_valid <= 1'b0; r_resp_status <= 2'b00;
            r_drp_en <= 1'b0; r_drp_we <= 1'b0; r_drp_adr <= '0; r_drp_di <= '0;
            r_mmcm_rst <= 1'b0;
        end else begin
            r_div <= w_div_nxt; r_rd_hi <= w_rd_hi_nxt; r_code <= w_code_nxt;
            r_req_ready  <= w_idle_nxt;
            r_busy       <= !w_idle_nxt;
            r_resp_valid <= (r_state == S_RESP);
            if (r_state == S_RESP) r_resp_status <= r_code;
            r_drp_en <= w_en_nxt; r_drp_we <= w_we_nxt;
            r_drp_adr <= w_adr_nxt; r_drp_di <= w_di_nxt;
            r_mmcm_rst <= w_rst_nxt;
        end
    end

    // DRP ready timer, reset-hold counter and post-release lock timer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drp_cnt <= '0; r_rst_cnt <= '0; r_lock_cnt <= '0;
        end else begin
            if (r_state inside {S_RD1, S_WR1, S_RD2, S_WR2})
                r_drp_cnt <= c_DCNT_W'(1);
            else if (r_state inside {S_WT_RD1, S_WT_WR1, S_WT_RD2, S_WT_WR2} && r_drp_cnt < c_DRDY_TO)
                r_drp_cnt <= r_drp_cnt + 1'b1;
            if (w_state_nxt == S_ASSERT_RST)
                r_rst_cnt <= c_RCNT_W'(1);
            else if (r_mmcm_rst && r_rst_cnt < c_RST_MIN)
                r_rst_cnt <= r_rst_cnt + 1'b1;
            if (r_state == S_RELEASE)
                r_lock_cnt <= '0;
            else if (r_state == S_WAIT_LOCK && r_lock_cnt < c_LOCK_TO)
                r_lock_cnt <= r_lock_cnt + 1'b1;
        end
    end

    // Two-flop synchronizer for the asynchronous LOCKED pin
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock_meta <= 1'b0; r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= bus.mmcm_locked_i; r_lock_sync <= r_lock_meta;
        end
    end

    assign bus.req_ready_o   = r_req_ready;
    assign bus.busy_o        = r_busy;
    assign bus.resp_valid_o  = r_resp_valid;
    assign bus.resp_status_o = r_resp_status;
    assign bus.drp_en_o      = r_drp_en;
    assign bus.drp_we_o      = r_drp_we;
    assign bus.drp_adr_o     = r_drp_adr;
    assign bus.drp_di_o      = r_drp_di;
    assign bus.mmcm_rst_o    = r_mmcm_rst;
endmodule
`default_nettype wire

// File: tb/tb_rvlab_mmcm_drp_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rvlab_mmcm_drp_seq
//  Brief    : Self-checking bench for rvlab_mmcm_drp_seq with a DRP/MMCM
//             responder and a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rvlab_mmcm_drp_seq;
    localparam int DT    = 64;
    localparam int LT    = 200;
    localparam int RMIN  = 16;
    localparam int LIMIT = LT + 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    initial forever #5 clk = ~clk;

    rvlab_mmcm_drp_seq_if bus();

    rvlab_mmcm_drp_seq #(
        .DIV_MIN(6), .DIV_MAX(128), .DRDY_TIMEOUT(DT),
        .LOCK_TIMEOUT(LT), .RST_MIN_CYCLES(RMIN)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- DRP and MMCM behavioural environment ----------------
    bit          drp_mute = 1'b0;
    bit          lock_stuck = 1'b0;
    logic [15:0] rb1 = 16'hF000, rb2 = 16'hFC00;
    int          pend = 0;
    logic [6:0]  pend_adr = 7'h0;
    int          lcnt = 10;

    initial begin
        bus.drp_rdy_i = 1'b0; bus.drp_do_i = 16'hDEAD; bus.mmcm_locked_i = 1'b1;
        forever begin
            @(negedge clk);
            bus.drp_rdy_i = 1'b0;
            bus.drp_do_i  = 16'hDEAD;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.drp_rdy_i = 1'b1;
                    bus.drp_do_i  = (pend_adr == 7'h08) ? rb1 : rb2;
                end
            end
            if (bus.drp_en_o === 1'b1 && !drp_mute) begin
                pend = 2; pend_adr = bus.drp_adr_o;
            end
            if (bus.mmcm_rst_o === 1'b1) lcnt = 0;
            else if (lcnt < 10) lcnt++;
            bus.mmcm_locked_i = !lock_stuck && (lcnt >= 10) && (bus.mmcm_rst_o !== 1'b1);
        end
    end

    // ---------------- reference model ----------------
    function automatic int exp_status(int d, bit mute, bit stuck);
        if (d < 6 || d > 128) return 1;
        if (mute) return 2;
        if (stuck) return 3;
        return 0;
    endfunction

    function automatic logic [15:0] reg1_val(int d, logic [15:0] rb);
        int hi = d / 2;
        int lo = d - hi;
        return (rb & 16'hF000) | 16'((hi % 64) * 64 + (lo % 64));
    endfunction

    function automatic logic [15:0] reg2_val(int d, logic [15:0] rb);
        return (rb & 16'hFC00) | 16'((d % 2) * 128);
    endfunction

    // One request from issue to the cycle after its response
    task automatic do_req(input int d, input logic [15:0] r1, input logic [15:0] r2,
                          input bit mute, input bit stuck, input bit hold, input int next_d);
        int cyc, en_first, rst_first, rel_cyc, rst_cycles, ready_viol, st, n;
        logic last_rst;
        logic [23:0] got[$];
        logic [23:0] expq[$];
        drp_mute = mute; lock_stuck = stuck; rb1 = r1; rb2 = r2;
        cyc = 0;
        while (bus.req_ready_o !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        chk("ready_before_req", 32'(bus.req_ready_o), 1);
        bus.req_valid_i = 1'b1; bus.req_div_i = 8'(d);
        en_first = -1; rst_first = -1; rel_cyc = -1; rst_cycles = 0; ready_viol = 0;
        last_rst = 1'b0;
        for (cyc = 1; cyc <= LIMIT; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus.req_valid_i = hold;
                bus.req_div_i   = hold ? 8'(next_d) : 8'(d);
            end
            if (bus.resp_valid_o === 1'b1) break;
            if (bus.drp_en_o === 1'b1) begin
                got.push_back({bus.drp_we_o, bus.drp_adr_o, bus.drp_di_o});
                if (en_first < 0) en_first = cyc;
            end
            if (bus.mmcm_rst_o === 1'b1) begin
                rst_cycles++;
                if (rst_first < 0) rst_first = cyc;
            end else if (last_rst === 1'b1) rel_cyc = cyc;
            last_rst = bus.mmcm_rst_o;
            if (bus.req_ready_o !== 1'b0) ready_viol++;
        end
        st = exp_status(d, mute, stuck);
        chk($sformatf("resp_seen d=%0d", d), 32'(bus.resp_valid_o), 1);
        chk($sformatf("status d=%0d", d), 32'(bus.resp_status_o), 32'(st));
        chk("ready_low_while_busy", 32'(ready_viol), 0);
        chk("ready_low_at_resp", 32'(bus.req_ready_o), 0);
        if (st == 0 || st == 3) begin
            expq.push_back({1'b0, 7'h08, 16'h0000});
            expq.push_back({1'b1, 7'h08, reg1_val(d, r1)});
            expq.push_back({1'b0, 7'h09, 16'h0000});
            expq.push_back({1'b1, 7'h09, reg2_val(d, r2)});
        end else if (st == 2) begin
            expq.push_back({1'b0, 7'h08, 16'h0000});
        end
        chk($sformatf("drp_pulses d=%0d", d), 32'(got.size()), 32'(expq.size()));
        n = (got.size() < expq.size()) ? got.size() : expq.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("drp_access%0d d=%0d", i, d), 32'(got[i]), 32'(expq[i]));
        if (st == 1) begin
            chk("bad_resp_latency", 32'(cyc), 2);
            chk("bad_no_mmcm_rst", 32'(rst_cycles), 0);
        end else begin
            chk("rst_low_before_resp", 32'(last_rst), 0);
            chk("rst_first_cycle", 32'(rst_first), 1);
            chk("drp_first_cycle", 32'(en_first), 2);
        end
        if (st == 0 || st == 3)
            chk("rst_hold_min", 32'(rst_cycles >= RMIN), 1);
        if (st == 2)
            chk("drp_timeout_window", 32'(cyc >= DT && cyc <= DT + 8), 1);
        if (st == 3)
            chk("lock_timeout_window", 32'((cyc - rel_cyc) >= LT && (cyc - rel_cyc) <= LT + 8), 1);
        @(negedge clk);
        chk("resp_one_cycle", 32'(bus.resp_valid_o), 0);
        chk("ready_after_resp", 32'(bus.req_ready_o), 1);
        chk("status_held", 32'(bus.resp_status_o), 32'(st));
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        int d;
        bus.req_valid_i = 1'b0; bus.req_div_i = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready",   32'(bus.req_ready_o), 1);
        chk("rst_resp_valid",  32'(bus.resp_valid_o), 0);
        chk("rst_resp_status", 32'(bus.resp_status_o), 0);
        chk("rst_busy",        32'(bus.busy_o), 0);
        chk("rst_drp_bus",     32'({bus.drp_en_o, bus.drp_we_o, bus.drp_adr_o, bus.drp_di_o}), 0);
        chk("rst_mmcm_rst",    32'(bus.mmcm_rst_o), 0);

        do_req(18,  16'hF000, 16'hFC00, 0, 0, 0, 0);
        do_req(7,   16'hF000, 16'hFC00, 0, 0, 0, 0);
        do_req(5,   16'hF000, 16'hFC00, 0, 0, 0, 0);
        do_req(129, 16'hF000, 16'hFC00, 0, 0, 0, 0);
        do_req(6,   16'h1234, 16'hABCD, 0, 0, 0, 0);
        do_req(128, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
        do_req(20,  16'hF000, 16'hFC00, 1, 0, 0, 0);
        do_req(30,  16'hF000, 16'hFC00, 0, 1, 1, 40);
        do_req(40,  16'h5A5A, 16'hA5A5, 0, 0, 0, 0);

        // Reset in the middle of the sequence
        bus.req_valid_i = 1'b1; bus.req_div_i = 8'd50;
        drp_mute = 1'b0; lock_stuck = 1'b0;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.drp_en_o === 1'b1 && bus.drp_we_o === 1'b1) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk("midrst_pre_mmcm_rst", 32'(bus.mmcm_rst_o), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mmcm_rst",  32'(bus.mmcm_rst_o), 0);
        chk("midrst_drp_en",    32'(bus.drp_en_o), 0);
        chk("midrst_busy",      32'(bus.busy_o), 0);
        chk("midrst_req_ready", 32'(bus.req_ready_o), 1);
        pend = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(12, 16'hF000, 16'hFC00, 0, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            d = int'($urandom_range(0, 140));
            do_req(d, 16'($urandom), 16'($urandom),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/rvlab_mmcm_drp_seq.md
# rvlab_mmcm_drp_seq

Sequences a runtime change of the system-MMCM CLKOUT0 integer divider over the MMCM DRP port. It accepts one divide request at a time and holds the MMCM in reset for the whole update. It performs read-modify-write of ClkReg1 (0x08) and ClkReg2 (0x09), releases reset, waits for lock, then reports a status code. It sits between the clock-reconfiguration register front end (request side) and the MMCME2_ADV DRP/RST pins, in the board-clock domain.

## Interface
- `DIV_MIN`, 6: smallest accepted divide value (VCO 1200 MHz → 200 MHz max).
- `DIV_MAX`, 128: largest accepted divide value.
- `DRDY_TIMEOUT`, 64: cycles allowed from `drp_en_o` to `drp_rdy_i`.
- `LOCK_TIMEOUT`, 65535: cycles allowed from reset release to lock.
- `RST_MIN_CYCLES`, 16: minimum cycles `mmcm_rst_o` stays high.

Ports:
- `clk_i` in 1: board clock, also used as DCLK. One clock; reset is asynchronous, active-low.
- `rst_ni` in 1: asynchronous active-low reset.
- `req_valid_i` in 1: divide request valid.
- `req_ready_o` out 1: high only in IDLE.
- `req_div_i` in 8: requested CLKOUT0 divide.
- `resp_valid_o` out 1: one-cycle completion pulse.
- `resp_status_o` out 2: 00 ok, 01 bad divide, 10 DRP timeout, 11 lock timeout. Valid with `resp_valid_o` and held until the next response.
- `busy_o` out 1: state ≠ IDLE.
- `drp_en_o` out 1: DRP enable.
- `drp_we_o` out 1: DRP write enable.
- `drp_adr_o` out 7: DRP address.
- `drp_di_o` out 16: DRP write data.
- `drp_rdy_i` in 1: DRP ready.
- `drp_do_i` in 16: DRP read data.
- `mmcm_rst_o` out 1: MMCM RST.
- `mmcm_locked_i` in 1: MMCM LOCKED (asynchronous). Synchronized internally with 2 flops.

## Operation
- Request is accepted on the cycle where `req_valid_i & req_ready_o`. The divide value `d` is latched at acceptance.
- If `d` < DIV_MIN or `d` > DIV_MAX: go to RESP with status 01. No DRP access occurs and `mmcm_rst_o` is not touched.
- Field encoding, computed from the latched `d`:
  - high = d>>1
  - low = d − high
  - edge = d[0]
  - no_count = 0
  - Widths are 7 bits internally; high and low are truncated to 6 bits. d=128 encodes high=low=0 (64 each).
- ClkReg1 write data = {rd[15:12], high[5:0], low[5:0]}.
- ClkReg2 write data = {rd[15:10], 2'b00, edge, no_count, 6'b0}.
- FSM: IDLE → ASSERT_RST → RD1 → WT_RD1 → WR1 → WT_WR1 → RD2 → WT_RD2 → WR2 → WT_WR2 → HOLD → RELEASE → WAIT_LOCK → RESP → IDLE.
- ASSERT_RST: sets `mmcm_rst_o`=1 and starts the reset-hold counter.
- RDx/WRx: drive `drp_en_o` for exactly one cycle, with `drp_we_o` = 1 for WR. Address is 0x08 for RD1/WR1 and 0x09 for RD2/WR2.
- WT_x: waits for `drp_rdy_i`. On a read, `drp_do_i` is captured on the `drp_rdy_i` cycle.
- HOLD: waits until the reset-hold counter ≥ RST_MIN_CYCLES.
- RELEASE: `mmcm_rst_o`=0 and the lock timer is cleared.
- WAIT_LOCK: ignores the synchronized lock for the first 4 cycles (synchronizer flush). After that, lock high → RESP with 00; timer reaching LOCK_TIMEOUT → RESP with 11.
- DRP timeout: when a WT_x counter reaches DRDY_TIMEOUT, go to RELEASE and skip WAIT_LOCK. Go straight to RESP with status 10.
- Requests arriving while busy are not accepted (`req_ready_o`=0). There is no queueing.
- A `drp_rdy_i` outside any WT_x state is ignored.

## Timing
- Reset values: `req_ready_o`=1, `resp_valid_o`=0, `resp_status_o`=00, `busy_o`=0, all `drp_*_o`=0, `mmcm_rst_o`=0. Reset asserted mid-sequence releases `mmcm_rst_o` asynchronously.
- All outputs are registered. `drp_adr_o`/`drp_di_o`/`drp_we_o` are stable while `drp_en_o`=1 and are 0 otherwise.
- Acceptance at cycle 0 → `mmcm_rst_o`=1 at cycle 1 → first `drp_en_o` at cycle 2.
- A DRP read and the following write are separated by exactly one cycle after `drp_rdy_i`.
- Bad-divide response: `resp_valid_o` at cycle 2 after acceptance.
- `resp_valid_o` is high for exactly 1 cycle. `req_ready_o` returns high the cycle after the response.

## Test plan
- Model DRP with `drp_rdy_i` 2 cycles after `drp_en_o`, reading back 0xF000 and 0xFC00, and lock 10 cycles after release. Request d=18 → writes 0x08←0xF249 and 0x09←0xFC00, then status 00 with exactly 4 `drp_en_o` pulses.
- d=7 → ClkReg1 low=4/high=3 (0x08←0xF0C4) and ClkReg2 edge=1 (0x09←0xFC80).
- d=5 (below DIV_MIN) → status 01 at cycle 2, with no `drp_en_o` and no `mmcm_rst_o`. d=129 → status 01.
- `drp_rdy_i` never asserted → status 10 after DRDY_TIMEOUT cycles, with `mmcm_rst_o` low before `resp_valid_o`.
- Lock held low → status 11 after LOCK_TIMEOUT. A second `req_valid_i` during busy is not accepted until after the response.
- Assert `rst_ni` during WT_WR1 → `mmcm_rst_o` and `drp_en_o` drop immediately. After release, a new request d=12 completes with status 00.
